// File: rtl/watch_time_set_pkg.sv
// Shared watch types: field/state enums, calendar limits, max_days().
// Also intended for use by the watch/date counter.
package watch_pkg;

    typedef enum logic [2:0] {
        F_YEAR  = 3'd0,
        F_MONTH = 3'd1,
        F_DAY   = 3'd2,
        F_HOUR  = 3'd3,
        F_MIN   = 3'd4,
        F_SEC   = 3'd5
    } field_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_EDIT,
        S_COMMIT
    } state_e;

    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } wtime_t;

    localparam logic [7:0] YEAR_MIN  = 8'd0;
    localparam logic [7:0] YEAR_MAX  = 8'd255;
    localparam logic [7:0] MONTH_MIN = 8'd1;
    localparam logic [7:0] MONTH_MAX = 8'd12;
    localparam logic [7:0] DAY_MIN   = 8'd1;
    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] SEC_MAX   = 8'd59;

    // No leap years; invalid months fall back to 31.
    function automatic logic [7:0] max_days(input logic [7:0] month);
        logic [7:0] md;
        unique case (1'b1)
            (month == 8'd2): md = 8'd28;
            (month == 8'd4) || (month == 8'd6) ||
            (month == 8'd9) || (month == 8'd11): md = 8'd30;
            default: md = 8'd31;
        endcase
        return md;
    endfunction

endpackage

// File: rtl/watch_time_set_if.sv
// Button/time bus between debouncers, editor and watch/date counter.
// master drives buttons and cur_time; slave is the editor.
interface watch_time_set_if;

    logic        active;
    logic        clk1sec;
    logic        set_req;
    logic        btn_next;
    logic        btn_up;
    logic        btn_down;
    logic        btn_ok;
    logic        btn_cancel;
    logic [47:0] cur_time;

    logic        set_time;
    logic [47:0] edit_time;
    logic [2:0]  edit_field;
    logic [47:0] load_time;
    logic        load_valid;

    modport master (
        output active, clk1sec, set_req,
        output btn_next, btn_up, btn_down,
        output btn_ok, btn_cancel, cur_time,
        input  set_time, edit_time, edit_field,
        input  load_time, load_valid
    );

    modport slave (
        input  active, clk1sec, set_req,
        input  btn_next, btn_up, btn_down,
        input  btn_ok, btn_cancel, cur_time,
        output set_time, edit_time, edit_field,
        output load_time, load_valid
    );

endinterface

// File: rtl/watch_time_set_field_step.sv
// One field step: +/-1 with wrap over [min,max].
// Out-of-range input snaps to min on up, max on down.
module watch_field_step (
    input  logic [7:0] val_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [7:0] val_o
);

    logic oor;

    assign oor = (val_i < min_i) || (val_i > max_i);

    always_comb begin
        val_o = val_i;
        unique case (1'b1)
            (up_i && !down_i): begin
                if (oor || val_i == max_i) val_o = min_i;
                else                       val_o = val_i + 8'd1;
            end
            (down_i && !up_i): begin
                if (oor || val_i == min_i) val_o = max_i;
                else                       val_o = val_i - 8'd1;
            end
            default: val_o = val_i;
        endcase
    end

endmodule

// File: rtl/watch_time_set.sv
// Watch time editor: capture, step, validate and commit a 48-bit time.
// Optional WATCH_SET_TIMEOUT_EN aborts the edit after TIMEOUT_SEC idle seconds.
module watch_time_set
    import watch_pkg::*;
#(
    parameter int TIMEOUT_SEC = 30
) (
    input logic             clk,
    input logic             rst,
    watch_time_set_if.slave bus
);

    state_e      state_q;
    wtime_t      edit_time_q;
    field_e      edit_field_q;
    logic [47:0] load_time_q;
    logic        load_valid_q;
    logic        set_time_q;

    wtime_t      et;
    wtime_t      ed_d;
    field_e      field_d;
    logic [7:0]  sel_val;
    logic [7:0]  sel_min;
    logic [7:0]  sel_max;
    logic [7:0]  stepped;
    logic        any_btn;
    logic        step_en;

    assign et = edit_time_q;

    assign any_btn = bus.btn_next | bus.btn_up | bus.btn_down |
                     bus.btn_ok | bus.btn_cancel;
    assign step_en = bus.btn_up ^ bus.btn_down;

    always_comb begin
        sel_val = 8'd0;
        sel_min = 8'd0;
        sel_max = 8'd0;
        case (edit_field_q)
            F_YEAR:  begin sel_val = et.year;   sel_min = YEAR_MIN;  sel_max = YEAR_MAX;  end
            F_MONTH: begin sel_val = et.month;  sel_min = MONTH_MIN; sel_max = MONTH_MAX; end
            F_DAY:   begin sel_val = et.day;    sel_min = DAY_MIN;   sel_max = max_days(et.month); end
            F_HOUR:  begin sel_val = et.hour;   sel_min = 8'd0;      sel_max = HOUR_MAX;  end
            F_MIN:   begin sel_val = et.minute; sel_min = 8'd0;      sel_max = MIN_MAX;   end
            F_SEC:   begin sel_val = et.second; sel_min = 8'd0;      sel_max = SEC_MAX;   end
            default: ;
        endcase
    end

    watch_field_step u_step (
        .val_i  (sel_val),
        .min_i  (sel_min),
        .max_i  (sel_max),
        .up_i   (bus.btn_up),
        .down_i (bus.btn_down),
        .val_o  (stepped)
    );

    // A month step pulls day down to the new month's length in the same cycle.
    always_comb begin
        ed_d = et;
        case (edit_field_q)
            F_YEAR:  ed_d.year = stepped;
            F_MONTH: begin
                ed_d.month = stepped;
                if (et.day > max_days(stepped)) ed_d.day = max_days(stepped);
            end
            F_DAY:   ed_d.day    = stepped;
            F_HOUR:  ed_d.hour   = stepped;
            F_MIN:   ed_d.minute = stepped;
            F_SEC:   ed_d.second = stepped;
            default: ;
        endcase
    end

    assign field_d = (edit_field_q == F_SEC) ? F_YEAR
                   : field_e'(edit_field_q + 3'd1);

`ifdef WATCH_SET_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        unused_cfg;
    assign unused_cfg = 1'b0;
`else
    logic unused_cfg;
    assign unused_cfg = bus.clk1sec ^ (TIMEOUT_SEC != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            edit_time_q  <= '0;
            edit_field_q <= F_YEAR;
            load_time_q  <= '0;
            load_valid_q <= 1'b0;
            set_time_q   <= 1'b0;
`ifdef WATCH_SET_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            load_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.set_req && bus.active) begin
                        state_q    <= S_CAPTURE;
                        set_time_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    edit_time_q  <= bus.cur_time;
                    edit_field_q <= F_YEAR;
                    state_q      <= S_EDIT;
`ifdef WATCH_SET_TIMEOUT_EN
                    tmo_q        <= '0;
`endif
                end
                S_EDIT: begin
                    if (bus.active) begin
                        if (bus.btn_cancel) begin
                            state_q    <= S_IDLE;
                            set_time_q <= 1'b0;
                        end else if (bus.btn_ok) begin
                            state_q      <= S_COMMIT;
                            load_time_q  <= edit_time_q;
                            load_valid_q <= 1'b1;
                        end else if (bus.btn_next) begin
                            edit_field_q <= field_d;
                        end else if (step_en) begin
                            edit_time_q <= ed_d;
                        end
`ifdef WATCH_SET_TIMEOUT_EN
                        // A button in the expiry cycle keeps the edit alive.
                        if (any_btn) begin
                            tmo_q <= '0;
                        end else if (bus.clk1sec) begin
                            if (tmo_q >= 16'(TIMEOUT_SEC - 1)) begin
                                state_q    <= S_IDLE;
                                set_time_q <= 1'b0;
                                tmo_q      <= '0;
                            end else begin
                                tmo_q <= tmo_q + 16'd1;
                            end
                        end
`endif
                    end
                end
                S_COMMIT: begin
                    state_q    <= S_IDLE;
                    set_time_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic unused_btn;
    assign unused_btn = any_btn & unused_cfg;

    assign bus.set_time   = set_time_q;
    assign bus.edit_time  = edit_time_q;
    assign bus.edit_field = edit_field_q;
    assign bus.load_time  = load_time_q;
    assign bus.load_valid = load_valid_q;

endmodule

// File: tb/tb_watch_time_set.sv
// Scoreboard bench for watch_time_set: commits are queued, a monitor checks load strobes.
// Timeout checks run when WATCH_SET_TIMEOUT_EN is defined.
module tb_watch_time_set;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    watch_time_set_if ifc ();

    watch_time_set #(
        .TIMEOUT_SEC (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    localparam logic [4:0] B_CANCEL = 5'b10000;
    localparam logic [4:0] B_OK     = 5'b01000;
    localparam logic [4:0] B_NEXT   = 5'b00100;
    localparam logic [4:0] B_UP     = 5'b00010;
    localparam logic [4:0] B_DN     = 5'b00001;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] exp_q[$];

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] tw(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    always @(negedge clk) begin
        if (rst && ifc.load_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_load: got %h expected no load", ifc.load_time);
            end else begin
                check("load_time", ifc.load_time, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] m);
        {ifc.btn_cancel, ifc.btn_ok, ifc.btn_next, ifc.btn_up, ifc.btn_down} = m;
        tick();
        {ifc.btn_cancel, ifc.btn_ok, ifc.btn_next, ifc.btn_up, ifc.btn_down} = 5'b0;
    endtask

    task automatic nexts(input int n);
        for (int i = 0; i < n; i++) press(B_NEXT);
    endtask

    task automatic enter(input logic [47:0] t);
        ifc.cur_time = t;
        ifc.set_req  = 1'b1;
        tick();
        ifc.set_req = 1'b0;
        check("set_time_after_req", 48'(ifc.set_time), 48'd1);
        tick();
        check("capture", ifc.edit_time, t);
        check("capture_field", 48'(ifc.edit_field), 48'd0);
    endtask

    task automatic commit(input logic [47:0] t);
        exp_q.push_back(t);
        press(B_OK);
        check("commit_set_time", 48'(ifc.set_time), 48'd1);
        check("commit_valid", 48'(ifc.load_valid), 48'd1);
        tick();
        check("post_commit_set_time", 48'(ifc.set_time), 48'd0);
        check("post_commit_valid", 48'(ifc.load_valid), 48'd0);
    endtask

    task automatic sec_pulse();
        ifc.clk1sec = 1'b1;
        tick();
        ifc.clk1sec = 1'b0;
        tick();
    endtask

    initial begin
        ifc.active     = 1'b1;
        ifc.clk1sec    = 1'b0;
        ifc.set_req    = 1'b0;
        ifc.btn_next   = 1'b0;
        ifc.btn_up     = 1'b0;
        ifc.btn_down   = 1'b0;
        ifc.btn_ok     = 1'b0;
        ifc.btn_cancel = 1'b0;
        ifc.cur_time   = tw(9, 9, 9, 9, 9, 9);

        #12;
        check("rst_set_time", 48'(ifc.set_time), 48'd0);
        check("rst_load_valid", 48'(ifc.load_valid), 48'd0);
        check("rst_load_time", ifc.load_time, 48'd0);
        check("rst_edit_time", ifc.edit_time, 48'd0);
        check("rst_edit_field", 48'(ifc.edit_field), 48'd0);
        rst = 1'b1;
        tick();

        enter(tw(21, 5, 30, 0, 0, 0));
        commit(tw(21, 5, 30, 0, 0, 0));

        enter(tw(21, 1, 31, 10, 20, 30));
        nexts(1);
        check("clamp_field", 48'(ifc.edit_field), 48'd1);
        press(B_UP);
        check("day_clamp", ifc.edit_time, tw(21, 2, 28, 10, 20, 30));
        commit(tw(21, 2, 28, 10, 20, 30));

        enter(tw(255, 1, 15, 23, 59, 59));
        nexts(3);
        press(B_UP);
        check("hour_wrap", ifc.edit_time, tw(255, 1, 15, 0, 59, 59));
        nexts(2);
        check("field_5", 48'(ifc.edit_field), 48'd5);
        press(B_NEXT);
        check("field_wrap", 48'(ifc.edit_field), 48'd0);
        press(B_NEXT);
        press(B_DN);
        check("month_wrap", ifc.edit_time, tw(255, 12, 15, 0, 59, 59));
        nexts(5);
        press(B_UP);
        check("year_wrap", ifc.edit_time, tw(0, 12, 15, 0, 59, 59));
        commit(tw(0, 12, 15, 0, 59, 59));

        enter(tw(10, 0, 0, 25, 60, 61));
        press(B_NEXT);
        press(B_UP);
        check("norm_month", ifc.edit_time, tw(10, 1, 0, 25, 60, 61));
        press(B_NEXT);
        press(B_DN);
        press(B_NEXT);
        press(B_UP);
        press(B_NEXT);
        press(B_DN);
        press(B_NEXT);
        press(B_UP);
        check("norm_all", ifc.edit_time, tw(10, 1, 31, 0, 59, 0));
        commit(tw(10, 1, 31, 0, 59, 0));

        enter(tw(5, 4, 1, 0, 0, 0));
        nexts(2);
        press(B_DN);
        check("april_day_wrap", ifc.edit_time, tw(5, 4, 30, 0, 0, 0));
        commit(tw(5, 4, 30, 0, 0, 0));

        enter(tw(7, 7, 7, 7, 7, 7));
        press(B_UP | B_DN);
        check("up_down_nop", ifc.edit_time, tw(7, 7, 7, 7, 7, 7));
        press(B_CANCEL | B_OK);
        check("cancel_wins", 48'(ifc.set_time), 48'd0);
        tick();
        check("cancel_no_load", 48'(ifc.load_valid), 48'd0);

        enter(tw(30, 6, 15, 12, 0, 0));
        ifc.active = 1'b0;
        press(B_UP);
        press(B_OK);
        check("inactive_hold", ifc.edit_time, tw(30, 6, 15, 12, 0, 0));
        check("inactive_set_time", 48'(ifc.set_time), 48'd1);
        ifc.active = 1'b1;
        commit(tw(30, 6, 15, 12, 0, 0));

        enter(tw(1, 2, 3, 4, 5, 6));
        press(B_NEXT);
        rst = 1'b0;
        #1;
        check("midrst_set_time", 48'(ifc.set_time), 48'd0);
        check("midrst_field", 48'(ifc.edit_field), 48'd0);
        check("midrst_valid", 48'(ifc.load_valid), 48'd0);
        tick();
        rst = 1'b1;
        tick();

`ifdef WATCH_SET_TIMEOUT_EN
        enter(tw(3, 3, 3, 3, 3, 3));
        sec_pulse();
        sec_pulse();
        check("tmo_pre", 48'(ifc.set_time), 48'd1);
        sec_pulse();
        check("tmo_expire", 48'(ifc.set_time), 48'd0);
        enter(tw(3, 3, 3, 3, 3, 3));
        sec_pulse();
        sec_pulse();
        press(B_UP);
        sec_pulse();
        sec_pulse();
        check("tmo_reset_by_btn", 48'(ifc.set_time), 48'd1);
        press(B_CANCEL);
`else
        enter(tw(3, 3, 3, 3, 3, 3));
        for (int i = 0; i < 5; i++) sec_pulse();
        check("no_tmo", 48'(ifc.set_time), 48'd1);
        press(B_CANCEL);
`endif

        repeat (3) tick();
        check("pending_loads", 48'(exp_q.size()), 48'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
